// File: rtl/asin_angle_pkg.sv
// rtl/asin_angle_pkg.sv - shared constants, FSM encoding and quadrant helper for asin_angle
package asin_angle_pkg;

  localparam int    ROM_DEPTH = 64;
  localparam int    ROM_WIDTH = 8;
  localparam int    PI_BY_2   = 90;
  localparam string ROM_FILE  = "sin_table_64x8.hex";

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    MAP    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Unfold a first-quadrant angle using the operand signs; a full turn folds back to 0.
  function automatic logic [8:0] quadrant_map(input logic [8:0] theta,
                                              input logic       s_neg,
                                              input logic       c_neg);
    logic [8:0] half;
    logic [8:0] full;
    logic [8:0] r;
    half = 9'(2 * PI_BY_2);
    full = 9'(4 * PI_BY_2);
    case ({s_neg, c_neg})
      2'b00:   r = theta;
      2'b01:   r = half - theta;
      2'b11:   r = half + theta;
      default: r = full - theta;
    endcase
    if (r == full) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/sine_rom.sv
// rtl/sine_rom.sv - 64x8 quarter-wave sine table, rom[i] = floor(255*sin(i*pi/128))
module sine_rom
  import asin_angle_pkg::*;
(
  input  logic [$clog2(ROM_DEPTH)-1:0] addr,
  output logic [ROM_WIDTH-1:0]         data
);

  // Same table as the forward sine block, so asin(sin(x)) round trips stay consistent.
  localparam logic [ROM_WIDTH-1:0] TABLE [ROM_DEPTH] = '{
    8'd0,   8'd6,   8'd12,  8'd18,  8'd24,  8'd31,  8'd37,  8'd43,
    8'd49,  8'd55,  8'd61,  8'd68,  8'd74,  8'd79,  8'd85,  8'd91,
    8'd97,  8'd103, 8'd109, 8'd114, 8'd120, 8'd125, 8'd131, 8'd136,
    8'd141, 8'd146, 8'd151, 8'd156, 8'd161, 8'd166, 8'd171, 8'd175,
    8'd180, 8'd184, 8'd188, 8'd193, 8'd197, 8'd201, 8'd204, 8'd208,
    8'd212, 8'd215, 8'd218, 8'd221, 8'd224, 8'd227, 8'd230, 8'd233,
    8'd235, 8'd237, 8'd240, 8'd242, 8'd244, 8'd245, 8'd247, 8'd248,
    8'd250, 8'd251, 8'd252, 8'd253, 8'd253, 8'd254, 8'd254, 8'd254
  };

  assign data = TABLE[addr];

endmodule

// File: rtl/asin_angle.sv
// rtl/asin_angle.sv - recovers a 0..359 degree angle from a sine sample and cosine sign
module asin_angle #(
  parameter int ROM_DEPTH = asin_angle_pkg::ROM_DEPTH,
  parameter int ROM_WIDTH = asin_angle_pkg::ROM_WIDTH,
  parameter int PI_BY_2   = asin_angle_pkg::PI_BY_2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] sin_val,
  input  logic [15:0] cos_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  angle_out
);
  import asin_angle_pkg::*;

  localparam int IW = $clog2(ROM_DEPTH);
  localparam int BW = $clog2(IW);
  localparam logic [ROM_WIDTH-1:0] MAG_MAX = '1;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [BW-1:0]        bit_n;
  logic [ROM_WIDTH-1:0] mag;
  logic                 sin_neg;
  logic                 cos_neg;

  logic [IW-1:0]        cand;
  logic [ROM_WIDTH-1:0] rom_q;
  logic [16:0]          abs_in;
  logic [ROM_WIDTH-1:0] mag_in;
  logic [12:0]          prod;
  logic [8:0]           theta;

  // 17-bit negation keeps |-32768| representable before saturation.
  assign abs_in = sin_val[15] ? (17'd0 - {1'b1, sin_val}) : {1'b0, sin_val};
  assign mag_in = (abs_in > 17'(MAG_MAX)) ? MAG_MAX : abs_in[ROM_WIDTH-1:0];

  assign cand  = idx | (IW'(1) << bit_n);
  assign prod  = 13'(PI_BY_2) * 13'(idx);
  assign theta = 9'(prod >> IW);

  sine_rom u_sine_rom (
    .addr (cand),
    .data (rom_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      angle_out <= '0;
      idx       <= '0;
      bit_n     <= '0;
      mag       <= '0;
      sin_neg   <= 1'b0;
      cos_neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mag      <= mag_in;
            sin_neg  <= sin_val[15];
            cos_neg  <= cos_val[15];
            idx      <= '0;
            bit_n    <= BW'(IW - 1);
            in_ready <= 1'b0;
            state    <= SEARCH;
          end
        end
        // Binary search for the largest index whose table entry does not exceed mag.
        SEARCH: begin
          if (rom_q <= mag) idx <= cand;
          if (bit_n == '0) state <= MAP;
          else             bit_n <= bit_n - 1'b1;
        end
        MAP: begin
          angle_out <= quadrant_map(theta, sin_neg, cos_neg);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asin_angle.sv
// tb/tb_asin_angle.sv - self-checking bench for asin_angle against a behavioural reference
module tb_asin_angle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] sin_val = '0;
  logic [15:0] cos_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [8:0]  angle_out;

  int vectors = 0;
  int miscompares = 0;
  int rom_tab [64];

  asin_angle dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sin_val   (sin_val),
    .cos_val   (cos_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle_out (angle_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    vectors++;
    if (obs !== expd) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expd);
    end
  endtask

  // Reference: arcsine by exhaustive table scan, then quadrant by operand signs.
  function automatic int ref_angle(input int s, input int c);
    int m, best, th, r;
    m = (s < 0) ? -s : s;
    if (m > 255) m = 255;
    best = 0;
    for (int i = 0; i < 64; i++) if (rom_tab[i] <= m) best = i;
    th = (90 * best) / 64;
    if (s >= 0 && c >= 0)     r = th;
    else if (s >= 0)          r = 180 - th;
    else if (c < 0)           r = 180 + th;
    else                      r = 360 - th;
    return (r == 360) ? 0 : r;
  endfunction

  function automatic int fwd_mag(input int t);
    return (t >= 90) ? 255 : rom_tab[(t * 64) / 90];
  endfunction

  task automatic run(input logic [15:0] s, input logic [15:0] c, input bit noise,
                     output logic [8:0] ang, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    in_valid = 1'b1;
    sin_val  = s;
    cos_val  = c;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        sin_val  = 16'($urandom);
        cos_val  = 16'($urandom);
      end
    end
    in_valid = 1'b0;
    if (!out_valid) check("done_timeout", out_valid, 1);
    ang = angle_out;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  typedef struct { int s; int c; int a; } dir_t;
  dir_t dirs [7] = '{
    '{0, 200, 0}, '{255, 0, 88}, '{0, -200, 180}, '{-255, 0, 272},
    '{-255, -1, 268}, '{1000, 5, 88}, '{-32768, 0, 272}
  };

  initial begin
    logic [8:0] ang;
    int lat, n, sv, cv, t, d, first, second;
    bit seen;

    for (int i = 0; i < 64; i++)
      rom_tab[i] = int'($floor(255.0 * $sin(real'(i) * 3.14159265358979 / 128.0)));

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_angle", angle_out, 0);
    rst_n = 1'b1;

    foreach (dirs[i]) begin
      run(16'(dirs[i].s), 16'(dirs[i].c), 1'b0, ang, lat);
      check($sformatf("dir%0d_angle", i), ang, dirs[i].a);
      check($sformatf("dir%0d_latency", i), lat, 8);
    end

    // Back-pressure in DONE with in_valid noise: result must hold.
    @(negedge clk);
    in_valid = 1'b1; sin_val = 16'd255; cos_val = 16'(-100);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", out_valid, 1);
      check("hold_angle", angle_out, 92);
      check("hold_in_ready", in_ready, 0);
      in_valid = 1'(k % 2 == 0);
      sin_val  = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("hold_angle_end", angle_out, 92);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("hold_release_ready", in_ready, 1);
    check("hold_release_valid", out_valid, 0);

    // Reset during the third SEARCH cycle aborts cleanly.
    @(negedge clk);
    in_valid = 1'b1; sin_val = 16'd255; cos_val = 16'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_angle", angle_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("midrst_no_stale", seen, 0);
    run(16'd255, 16'd0, 1'b0, ang, lat);
    check("midrst_next_angle", ang, 88);

    // Throughput with both handshakes held high.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; sin_val = 16'd255; cos_val = 16'd0;
    first = -1; second = -1;
    for (int k = 0; k < 40 && second < 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = k;
        else second = k;
      end
    end
    check("throughput_period", second - first, 9);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;

    // Randomised operands with busy-time noise on the input port.
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 2))
        0: sv = int'($urandom_range(0, 600)) - 300;
        1: sv = int'($urandom_range(0, 65535)) - 32768;
        default: begin
          sv = rom_tab[$urandom_range(0, 63)] + int'($urandom_range(0, 2)) - 1;
          if ($urandom_range(0, 1) == 1) sv = -sv;
        end
      endcase
      cv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 65535)) - 32768;
      run(16'(sv), 16'(cv), 1'b1, ang, lat);
      check($sformatf("rand s=%0d c=%0d", sv, cv), ang, ref_angle(sv, cv));
    end

    // Round trip from the forward sine over a full turn.
    for (int a = 0; a < 360; a++) begin
      cv = 1 + int'($urandom_range(0, 254));
      if (a < 90)       begin t = a;       sv = fwd_mag(t);                end
      else if (a == 90) begin t = 90;      sv = 255;          cv = 0;      end
      else if (a < 180) begin t = 180 - a; sv = fwd_mag(t);   cv = -cv;    end
      else if (a < 270) begin t = a - 180; sv = -fwd_mag(t);  cv = -cv;    end
      else if (a == 270) begin t = 90;     sv = -255;         cv = 0;      end
      else              begin t = 360 - a; sv = -fwd_mag(t);               end
      run(16'(sv), 16'(cv), 1'b0, ang, lat);
      d = int'(ang) - a;
      if (d < 0) d = -d;
      if (d > 180) d = 360 - d;
      check($sformatf("roundtrip a=%0d err", a), (d <= 2) ? 0 : d, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/asin_angle.md
ASIN_ANGLE -- requirements
Module: asin_angle

Interface
REQ-001 Parameter ROM_DEPTH, default 64, SHALL be the number of sine ROM entries covering 0 to 90 degrees.
REQ-002 Parameter ROM_WIDTH, default 8, SHALL be the ROM magnitude width in bits.
REQ-003 Parameter PI_BY_2, default 90, SHALL be the quarter-turn expressed in degrees.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL mean sin_val/cos_val carry a request.
REQ-007 in_ready  output  1  SHALL mean the block accepts a request this cycle.
REQ-008 sin_val  input  16  SHALL be the signed two's-complement sine sample; full scale is +/-255.
REQ-009 cos_val  input  16  SHALL be the signed cosine sample; only its sign is used.
REQ-010 out_valid  output  1  SHALL mean angle_out holds a result.
REQ-011 out_ready  input  1  SHALL mean the consumer takes the result this cycle.
REQ-012 angle_out  output  9  SHALL be the recovered angle in degrees, 0 to 359.

Function
REQ-013 The FSM SHALL have four states: IDLE, SEARCH, MAP and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-015 A request SHALL be accepted on a rising edge with in_valid=1 and in_ready=1.
  - On acceptance, mag=|sin_val|, sin_neg=sin_val[15] and cos_neg=cos_val[15] SHALL be latched.
  - The FSM SHALL then move to SEARCH.
REQ-016 mag SHALL saturate to 255 when |sin_val| > 255; |-32768| SHALL saturate to 255.
REQ-017 SEARCH SHALL last exactly 6 cycles, one index bit per cycle from bit 5 down to bit 0.
  - cand = idx OR (1<<b).
  - idx SHALL take cand when rom[cand] <= mag; otherwise idx is unchanged.
  - idx SHALL start at 0.
REQ-018 The search result SHALL be the largest idx with rom[idx] <= mag; the ROM is monotonic non-decreasing and rom[0]=0.
REQ-019 MAP SHALL compute theta = floor(90*idx/64) (range 0 to 88) in one cycle, using 13-bit unsigned intermediate arithmetic.
REQ-020 MAP SHALL select the quadrant as follows:
  - sin_neg=0, cos_neg=0: theta.
  - sin_neg=0, cos_neg=1: 180-theta.
  - sin_neg=1, cos_neg=1: 180+theta.
  - sin_neg=1, cos_neg=0: 360-theta.
REQ-021 A MAP result of 360 SHALL wrap to 0.
REQ-022 In DONE, out_valid SHALL be 1 and angle_out SHALL hold steady until a cycle with out_ready=1.
  - On that cycle the FSM SHALL return to IDLE.
REQ-023 Latency from the acceptance edge to out_valid=1 SHALL be 8 cycles.
  - Minimum throughput SHALL be one result per 9 cycles with out_ready held at 1.
REQ-024 in_valid asserted while the block is busy SHALL be ignored and SHALL NOT corrupt the latched operands.
REQ-025 sin_val=0 SHALL be treated as non-negative.

Reset
REQ-026 On rst_n=0, the FSM SHALL go to IDLE immediately.
  - Reset values SHALL be: in_ready=1, out_valid=0, angle_out=0, idx=0.
  - mag, sin_neg and cos_neg SHALL all reset to 0.
REQ-027 Reset asserted mid-SEARCH, MAP or DONE SHALL abort the operation; no stale result SHALL appear after reset release.

Structure
REQ-028 A shared package SHALL hold ROM_DEPTH, ROM_WIDTH, PI_BY_2, the state encoding and the ROM file name "sin_table_64x8.hex".
REQ-029 The ROM SHALL be a sub-module named sine_rom.
  - 64x8, combinational read, initialised from the hex file.
  - Contents: rom[i] = floor(255*sin(i*pi/128)).
REQ-030 The ROM SHALL be the same table the forward sine block uses, so that round trips are consistent.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
  - sin=0, cos=200 -> angle_out=0 after 8 cycles.
  - sin=255, cos=0 -> 88; sin=0, cos=-200 -> 180; sin=-255, cos=0 -> 272; sin=-255, cos=-1 -> 268.
  - sin=1000, cos=5 -> saturation, 88; sin=-32768, cos=0 -> 272.
  - out_ready held 0 for 5 cycles in DONE -> angle_out and out_valid stable; in_ready=0; in_valid pulses ignored.
  - rst_n pulsed low during SEARCH cycle 3 -> out_valid=0 and in_ready=1 immediately; the next request sin=255, cos=0 -> 88.
  - Round trip: every forward-sine output for angles 0 to 359 -> |recovered-original| <= 2 degrees, excluding 90/270 ambiguity at the quadrant edges.
